// File: rtl/mux_arb_pkg.sv
// Shared types and round-robin pick helper for the 4-way arbiter; pure combinational helpers.
// No latency or flow control lives here.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First requester found scanning upward from last+1 with wrap; returns last if none.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// 4:1 one-bit data mux, purely combinational (zero latency).
// No flow control; select is held stable by the arbiter during backpressure.
module mux_4x1
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] data_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic               data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 channel arbiter, 1-cycle grant latency, valid/ready output; stalled owners are never preempted.
// Optional HOLD_LIMIT_EN forces rotation after MAX_BEATS transfers when another requester waits.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data_in,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               data_out,
    output logic               out_valid,
    output logic               busy
);

    if (MAX_BEATS < 1 || MAX_BEATS > (2**CNT_W) - 1) begin : g_bad_cfg
        $error("mux4_rr_arbiter: MAX_BEATS must be in 1..2**CNT_W-1");
    end

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [SEL_W-1:0]     idle_win, next_win;
    logic [NUM_REQ-1:0]   others;

    assign others    = req & ~(NUM_REQ'(1) << sel_q);
    assign idle_win  = rr_pick(req, last_q);
    assign next_win  = rr_pick(others, sel_q);
    assign out_valid = (gnt_q != '0) && req[sel_q];

`ifdef HOLD_LIMIT_EN
    logic             xfer;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign xfer    = out_valid && out_ready;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`else
    // Arbitration ignores backpressure entirely when beats are not limited.
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef HOLD_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d = ST_GRANT;
                    sel_d   = idle_win;
                    gnt_d   = NUM_REQ'(1) << idle_win;
`ifdef HOLD_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!req[sel_q]) begin
                    last_d = sel_q;
                    if (others != '0) begin
                        sel_d = next_win;
                        gnt_d = NUM_REQ'(1) << next_win;
`ifdef HOLD_LIMIT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef HOLD_LIMIT_EN
                else if (xfer) begin
                    // Hitting the limit rotates only if someone else is waiting.
                    if (cnt_inc == CNT_W'(MAX_BEATS)) begin
                        cnt_d = '0;
                        if (others != '0) begin
                            last_d = sel_q;
                            sel_d  = next_win;
                            gnt_d  = NUM_REQ'(1) << next_win;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
`ifdef HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == ST_GRANT);

    mux_4x1 u_mux (
        .data_i (data_in),
        .sel_i  (sel_q),
        .data_o (data_out)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       out_ready;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       data_out;
    logic       out_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index (-1 when idle), last released owner, held select, beats in grant.
    int m_owner;
    int m_last;
    int m_sel;
    int m_beats;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_BEATS(MAXB), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rstn, input logic [3:0] r, input logic rdy);
        int         w;
        logic [3:0] oth;
        if (!rstn) begin
            m_owner = -1;
            m_sel   = 0;
            m_last  = 3;
            m_beats = 0;
        end else if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_beats = 0;
            end
        end else begin
            oth = r & ~(4'b0001 << m_owner);
            if (!r[m_owner]) begin
                m_last = m_owner;
                w = pick(oth, m_owner);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (rdy) begin
                if (m_beats < 15) m_beats++;
`ifdef HOLD_LIMIT_EN
                if (m_beats == MAXB) begin
                    m_beats = 0;
                    if (oth != 4'b0) begin
                        m_last  = m_owner;
                        w       = pick(oth, m_owner);
                        m_owner = w;
                        m_sel   = w;
                    end
                end
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        logic       ev;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        ev = (m_owner < 0) ? 1'b0 : req[m_owner];
        chk("model_gnt",       gnt,               eg);
        chk("model_sel",       {2'b00, sel},      4'(m_sel));
        chk("model_busy",      {3'b000, busy},    {3'b000, m_owner >= 0});
        chk("model_out_valid", {3'b000, out_valid}, {3'b000, ev});
        chk("model_data_out",  {3'b000, data_out}, {3'b000, data_in[m_sel]});
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_edge(rst_n, req, out_ready);
        #1;
    endtask

    initial begin
        logic [3:0] drops [4];
        logic [3:0] order [4];
        logic [3:0] exp_g;

        drops = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset held two cycles with every requester active.
        rst_n = 1'b0; req = 4'b1111; data_in = 4'b0000; out_ready = 1'b0;
        @(posedge clk);
        model_edge(rst_n, req, out_ready);
        #1;
        tick();
        chk("reset_gnt",  gnt,            4'b0000);
        chk("reset_busy", {3'b000, busy}, 4'b0000);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", gnt,          4'b0001);
        chk("first_sel", {2'b00, sel}, 4'b0000);

        // Each owner moves one beat then drops for a cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = 4'b1111;
            tick();
            req = drops[i];
            tick();
            chk("rr_order", gnt,            order[i]);
            chk("rr_busy",  {3'b000, busy}, 4'b0001);
        end

        // Stalled owner 2 with toggling data.
        req = 4'b0100;
        tick();
        chk("stall_gnt", gnt, 4'b0100);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in    = 4'($urandom);
            data_in[2] = i[0];
            #1;
            chk("stall_data",  {3'b000, data_out},  {3'b000, i[0]});
            chk("stall_valid", {3'b000, out_valid}, 4'b0001);
            tick();
            chk("stall_sel", {2'b00, sel}, 4'b0010);
            chk("stall_gnt_hold", gnt, 4'b0100);
        end

        // Beat limit with two contending requesters.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b0011; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
`ifdef HOLD_LIMIT_EN
            exp_g = (k < 4) ? 4'b0001 : 4'b0010;
`else
            exp_g = 4'b0001;
`endif
            chk("hold_limit_gnt", gnt, exp_g);
            tick();
        end

        // Reset in the middle of a grant to requester 2.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b0100;
        tick();
        tick();
        chk("mid_pre_gnt", gnt, 4'b0100);
        rst_n = 1'b0; req = 4'b1111;
        tick();
        chk("mid_rst_gnt",  gnt,            4'b0000);
        chk("mid_rst_busy", {3'b000, busy}, 4'b0000);
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", gnt, 4'b0001);

        // Single requester drops for one cycle and comes back.
        req = 4'b0100;
        tick();
        chk("drop_pre_gnt", gnt, 4'b0100);
        req = 4'b0000;
        tick();
        chk("drop_busy", {3'b000, busy}, 4'b0000);
        chk("drop_gnt",  gnt,            4'b0000);
        req = 4'b0100;
        tick();
        chk("regrant_gnt",  gnt,            4'b0100);
        chk("regrant_busy", {3'b000, busy}, 4'b0001);

        // Randomized traffic with sticky requests and occasional reset.
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            req       = req ^ (4'($urandom) & 4'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            data_in   = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
